// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Single-outstanding bridge from a core req/gnt/rvalid request
//               port to an APB4 master port (with pstrb). Sequences the
//               SETUP/ACCESS phases, absorbs slave wait states, maps pslverr
//               to a response error and aborts hung transfers after an
//               optional number of ACCESS cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   // core-side request interface
   input  logic                        req_i,
   output logic                        gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic                        we_i,
   input  logic [APB_DATA_WIDTH/8-1:0] be_i,
   input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
   output logic                        rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]   rdata_o,
   output logic                        err_o,
   // APB master port
   output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
   output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
   output logic                        pwrite_o,
   output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
   output logic                        psel_o,
   output logic                        penable_o,
   input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
   input  logic                        pready_i,
   input  logic                        pslverr_i
);

   // Counter must be able to hold TIMEOUT_CYCLES-1; keep at least one bit
   // so the declaration stays legal when the timeout is disabled.
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit c_TMO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                w_timeout;

   // The only combinational path from inputs to outputs: accept only when idle.
   assign gnt_o = req_i & (r_state == S_IDLE);

   // Abort condition: last permitted ACCESS cycle reached without pready.
   assign w_timeout = c_TMO_EN && (r_cnt == c_CNT_LAST);

   // Transfer sequencer; all APB and response outputs are registered here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o  <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         pstrb_o   <= '0;
         rvalid_o  <= 1'b0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (gnt_o) begin
                  paddr_o  <= addr_i;
                  pwrite_o <= we_i;
                  pwdata_o <= wdata_i;
                  // reads never strobe any byte lane
                  pstrb_o  <= we_i ? be_i : '0;
                  psel_o   <= 1'b1;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               penable_o <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready_i) begin
                  err_o     <= pslverr_i;
                  rdata_o   <= pwrite_o ? '0 : prdata_i;
                  rvalid_o  <= 1'b1;
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  r_state   <= S_RESP;
               end else if (w_timeout) begin
                  err_o     <= 1'b1;
                  rdata_o   <= '0;
                  rvalid_o  <= 1'b1;
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  r_state   <= S_RESP;
               end else if (c_TMO_EN) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               rvalid_o <= 1'b0;
               rdata_o  <= '0;
               err_o    <= 1'b0;
               r_cnt    <= '0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
